// File: rtl/io_responder.sv
// -----------------------------------------------------------------------------
// io_responder
//   Memory-mapped IO block for a small CPU. When A[31:28] == IO_BASE, offsets
//   in A[7:0] select these registers:
//     0x00  status   (load)  {29'b0, tx_drop, rx_nonempty, tx_ready}
//     0x04  rx data  (load)  {24'b0, FIFO head}; pops the RX FIFO if non-empty
//     0x08  tx data  (store) byte lane 0 is sent to the UART transmitter
//     0x10  cycle counter        (load)
//     0x14  instruction counter  (load)
//     0x18  counter clear        (store, any byte enable)
//
// Ports
//   Clock, Reset_n        single rising-edge clock, async active-low reset
//   A, Din                address and store data from the execute stage
//   Io_trans              IO byte write enables (nonzero = IO store)
//   Io_recv               IO load this cycle
//   Instr_valid           one instruction retired this cycle
//   Dout                  registered IO load data (1-cycle latency)
//   Tx_data/valid/ready   byte stream to the UART transmitter
//   Rx_data/valid/ready   byte stream from the UART receiver into the RX FIFO
// -----------------------------------------------------------------------------
module io_responder #(
    parameter int         RX_DEPTH = 4,
    parameter logic [3:0] IO_BASE  = 4'h8
) (
    input  logic        Clock,
    input  logic        Reset_n,
    input  logic [31:0] A,
    input  logic [31:0] Din,
    input  logic [3:0]  Io_trans,
    input  logic        Io_recv,
    input  logic        Instr_valid,
    output logic [31:0] Dout,
    output logic [7:0]  Tx_data,
    output logic        Tx_valid,
    input  logic        Tx_ready,
    input  logic [7:0]  Rx_data,
    input  logic        Rx_valid,
    output logic        Rx_ready
);

    localparam int PTR_W = $clog2(RX_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [0:0] {
        TX_IDLE = 1'b0,
        TX_HOLD = 1'b1
    } tx_state_e;

    // state registers
    tx_state_e          tx_state_q, tx_state_d;
    logic [7:0]         tx_data_q,  tx_data_d;
    logic               tx_drop_q,  tx_drop_d;
    logic [31:0]        dout_q,     dout_d;
    logic [31:0]        cyc_q,      cyc_d;
    logic [31:0]        instr_q,    instr_d;
    logic [PTR_W-1:0]   wr_ptr_q,   wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q,   rd_ptr_d;
    logic [CNT_W-1:0]   count_q,    count_d;
    logic [7:0]         mem_q [RX_DEPTH];
    logic [7:0]         mem_d [RX_DEPTH];

    // decode helpers
    logic               mapped_s;
    logic [7:0]         addr_s;
    logic               store_s;
    logic               load_s;
    logic               rx_nonempty_s;
    logic               rx_ready_s;
    logic               push_s;
    logic               pop_s;
    logic               tx_store_s;
    logic               cnt_clr_s;
    logic               status_load_s;
    logic [31:0]        rdata_s;

    // Address bits between the space select and the register offset are don't-care.
    logic               unused_bits_s;
    assign unused_bits_s = ^{A[27:8], Din[31:8]};

    assign Dout     = dout_q;
    assign Tx_data  = tx_data_q;
    assign Tx_valid = (tx_state_q == TX_HOLD);
    assign Rx_ready = rx_ready_s;

    // Access decode; a store with Io_recv set suppresses the load side entirely.
    always_comb begin
        mapped_s      = (A[31:28] == IO_BASE);
        addr_s        = A[7:0];
        store_s       = mapped_s && (Io_trans != 4'h0);
        load_s        = mapped_s && Io_recv && (Io_trans == 4'h0);
        rx_nonempty_s = (count_q != {CNT_W{1'b0}});
        rx_ready_s    = (count_q < CNT_W'(RX_DEPTH));
        push_s        = Rx_valid && rx_ready_s;
        pop_s         = load_s && (addr_s == 8'h04) && rx_nonempty_s;
        tx_store_s    = store_s && (addr_s == 8'h08) && Io_trans[0];
        cnt_clr_s     = store_s && (addr_s == 8'h18);
        status_load_s = load_s && (addr_s == 8'h00);
    end

    // Load data mux; reads reflect pre-edge register values.
    always_comb begin
        rdata_s = 32'h0000_0000;
        if (mapped_s) begin
            case (addr_s)
                8'h00:   rdata_s = {29'h0, tx_drop_q, rx_nonempty_s, (tx_state_q == TX_IDLE)};
                8'h04:   rdata_s = rx_nonempty_s ? {24'h0, mem_q[rd_ptr_q]} : 32'h0000_0000;
                8'h10:   rdata_s = cyc_q;
                8'h14:   rdata_s = instr_q;
                default: rdata_s = 32'h0000_0000;
            endcase
        end else begin
            rdata_s = 32'h0000_0000;
        end
    end

    // Dout capture: only on Io_recv; a concurrent store forces zero.
    always_comb begin
        dout_d = dout_q;
        if (Io_recv) begin
            dout_d = (Io_trans != 4'h0) ? 32'h0000_0000 : rdata_s;
        end else begin
            dout_d = dout_q;
        end
    end

    // TX holding register FSM and sticky drop flag.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_data_d  = tx_data_q;
        tx_drop_d  = tx_drop_q;
        case (tx_state_q)
            TX_IDLE: begin
                if (tx_store_s) begin
                    tx_data_d  = Din[7:0];
                    tx_state_d = TX_HOLD;
                end else begin
                    tx_state_d = TX_IDLE;
                end
            end
            TX_HOLD: begin
                if (Tx_ready) begin
                    tx_state_d = TX_IDLE;
                end else begin
                    tx_state_d = TX_HOLD;
                end
            end
            default: begin
                tx_state_d = TX_IDLE;
            end
        endcase
        // A drop in the same cycle as a status read keeps the flag set.
        if (tx_store_s && (tx_state_q == TX_HOLD)) begin
            tx_drop_d = 1'b1;
        end else if (status_load_s) begin
            tx_drop_d = 1'b0;
        end else begin
            tx_drop_d = tx_drop_q;
        end
    end

    // RX FIFO pointers, occupancy and storage; no bypass from push to pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        for (int i = 0; i < RX_DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (push_s) begin
            mem_d[wr_ptr_q] = Rx_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Free-running cycle and retired-instruction counters with store-clear.
    always_comb begin
        cyc_d   = cyc_q + 32'h0000_0001;
        instr_d = instr_q;
        if (cnt_clr_s) begin
            cyc_d   = 32'h0000_0000;
            instr_d = 32'h0000_0000;
        end else if (Instr_valid) begin
            instr_d = instr_q + 32'h0000_0001;
        end else begin
            instr_d = instr_q;
        end
    end

    // State register bank.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            tx_state_q <= TX_IDLE;
            tx_data_q  <= 8'h00;
            tx_drop_q  <= 1'b0;
            dout_q     <= 32'h0000_0000;
            cyc_q      <= 32'h0000_0000;
            instr_q    <= 32'h0000_0000;
            wr_ptr_q   <= {PTR_W{1'b0}};
            rd_ptr_q   <= {PTR_W{1'b0}};
            count_q    <= {CNT_W{1'b0}};
            for (int i = 0; i < RX_DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else begin
            tx_state_q <= tx_state_d;
            tx_data_q  <= tx_data_d;
            tx_drop_q  <= tx_drop_d;
            dout_q     <= dout_d;
            cyc_q      <= cyc_d;
            instr_q    <= instr_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            for (int i = 0; i < RX_DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

endmodule

// File: tb/tb_io_responder.sv
// Directed testbench for io_responder: inputs change and outputs are sampled
// 1 time unit after each rising edge.
module tb_io_responder;

    logic        Clock = 1'b0;
    logic        Reset_n = 1'b0;
    logic [31:0] A = 32'h0;
    logic [31:0] Din = 32'h0;
    logic [3:0]  Io_trans = 4'h0;
    logic        Io_recv = 1'b0;
    logic        Instr_valid = 1'b0;
    logic [31:0] Dout;
    logic [7:0]  Tx_data;
    logic        Tx_valid;
    logic        Tx_ready = 1'b0;
    logic [7:0]  Rx_data = 8'h0;
    logic        Rx_valid = 1'b0;
    logic        Rx_ready;

    int tests_run = 0;
    int tests_failed = 0;

    io_responder #(.RX_DEPTH(4), .IO_BASE(4'h8)) dut (
        .Clock(Clock), .Reset_n(Reset_n), .A(A), .Din(Din), .Io_trans(Io_trans),
        .Io_recv(Io_recv), .Instr_valid(Instr_valid), .Dout(Dout),
        .Tx_data(Tx_data), .Tx_valid(Tx_valid), .Tx_ready(Tx_ready),
        .Rx_data(Rx_data), .Rx_valid(Rx_valid), .Rx_ready(Rx_ready)
    );

    always #5 Clock = ~Clock;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    // reset asserted away from the edge, released 1 unit after an edge
    task automatic apply_reset();
        Reset_n = 1'b0;
        #2;
    endtask

    task automatic release_reset();
        tick();
        tick();
        Reset_n = 1'b1;
    endtask

    task automatic do_load(input logic [31:0] addr);
        A = addr; Io_trans = 4'h0; Io_recv = 1'b1;
        tick();
        Io_recv = 1'b0;
    endtask

    task automatic do_store(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
        A = addr; Din = data; Io_trans = be;
        tick();
        Io_trans = 4'h0;
    endtask

    task automatic do_push(input logic [7:0] b);
        Rx_data = b; Rx_valid = 1'b1;
        tick();
        Rx_valid = 1'b0;
    endtask

    task automatic test_reset();
        tick();
        apply_reset();
        tests_run++; if (Dout !== 32'h0) begin tests_failed++; $display("FAIL reset_dout got %h want %h", Dout, 32'h0); end
        tests_run++; if (Tx_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_tx_valid got %b want 0", Tx_valid); end
        tests_run++; if (Tx_data !== 8'h0) begin tests_failed++; $display("FAIL reset_tx_data got %h want 00", Tx_data); end
        tests_run++; if (Rx_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_rx_ready got %b want 1", Rx_ready); end
        release_reset();
    endtask

    task automatic test_tx();
        Tx_ready = 1'b0;
        do_store(32'h8000_0008, 32'h0000_0041, 4'h1);
        for (int i = 0; i < 3; i++) begin
            tests_run++; if (Tx_valid !== 1'b1 || Tx_data !== 8'h41) begin tests_failed++; $display("FAIL tx_hold cyc %0d got valid=%b data=%h want 1/41", i, Tx_valid, Tx_data); end
            tick();
        end
        do_store(32'h8000_0008, 32'h0000_0042, 4'h1);
        tests_run++; if (Tx_data !== 8'h41) begin tests_failed++; $display("FAIL tx_drop_data got %h want 41", Tx_data); end
        do_load(32'h8000_0000);
        tests_run++; if (Dout !== 32'h4) begin tests_failed++; $display("FAIL tx_status_drop got %h want %h", Dout, 32'h4); end
        Tx_ready = 1'b1;
        tick();
        Tx_ready = 1'b0;
        tests_run++; if (Tx_valid !== 1'b0) begin tests_failed++; $display("FAIL tx_release got %b want 0", Tx_valid); end
        do_load(32'h8000_0000);
        tests_run++; if (Dout !== 32'h1) begin tests_failed++; $display("FAIL tx_status_idle got %h want %h", Dout, 32'h1); end
    endtask

    task automatic test_rx_fill();
        logic [7:0] exp_b [4];
        exp_b[0] = 8'h11; exp_b[1] = 8'h22; exp_b[2] = 8'h33; exp_b[3] = 8'h44;
        for (int i = 0; i < 4; i++) begin
            do_push(exp_b[i]);
        end
        tests_run++; if (Rx_ready !== 1'b0) begin tests_failed++; $display("FAIL rx_full_ready got %b want 0", Rx_ready); end
        do_push(8'h55);
        do_load(32'h8000_0000);
        tests_run++; if (Dout !== 32'h3) begin tests_failed++; $display("FAIL rx_status got %h want %h", Dout, 32'h3); end
        for (int i = 0; i < 4; i++) begin
            do_load(32'h8000_0004);
            tests_run++; if (Dout !== {24'h0, exp_b[i]}) begin tests_failed++; $display("FAIL rx_pop%0d got %h want %h", i, Dout, {24'h0, exp_b[i]}); end
            if (i == 0) begin
                tests_run++; if (Rx_ready !== 1'b1) begin tests_failed++; $display("FAIL rx_ready_after_pop got %b want 1", Rx_ready); end
            end
        end
        do_load(32'h8000_0004);
        tests_run++; if (Dout !== 32'h0) begin tests_failed++; $display("FAIL rx_empty got %h want 0", Dout); end
    endtask

    task automatic test_simul_push_pop();
        logic [7:0] exp_b [4];
        exp_b[0] = 8'hA1; exp_b[1] = 8'hA2; exp_b[2] = 8'hA3; exp_b[3] = 8'hA4;
        do_push(8'hA1);
        do_push(8'hA2);
        for (int i = 0; i < 4; i++) begin
            Rx_data = 8'hA3 + 8'(i); Rx_valid = 1'b1;
            do_load(32'h8000_0004);
            Rx_valid = 1'b0;
            tests_run++; if (Dout !== {24'h0, exp_b[i]}) begin tests_failed++; $display("FAIL simul_pop%0d got %h want %h", i, Dout, {24'h0, exp_b[i]}); end
        end
        do_load(32'h8000_0004);
        tests_run++; if (Dout !== 32'hA5) begin tests_failed++; $display("FAIL simul_tail0 got %h want %h", Dout, 32'hA5); end
        do_load(32'h8000_0004);
        tests_run++; if (Dout !== 32'hA6) begin tests_failed++; $display("FAIL simul_tail1 got %h want %h", Dout, 32'hA6); end
        do_load(32'h8000_0004);
        tests_run++; if (Dout !== 32'h0) begin tests_failed++; $display("FAIL simul_empty got %h want 0", Dout); end
    endtask

    task automatic test_no_bypass();
        Rx_data = 8'h77; Rx_valid = 1'b1;
        do_load(32'h8000_0004);
        Rx_valid = 1'b0;
        tests_run++; if (Dout !== 32'h0) begin tests_failed++; $display("FAIL bypass_pop got %h want 0", Dout); end
        do_load(32'h8000_0004);
        tests_run++; if (Dout !== 32'h77) begin tests_failed++; $display("FAIL bypass_queued got %h want %h", Dout, 32'h77); end
    endtask

    task automatic test_counters();
        apply_reset();
        release_reset();
        for (int i = 0; i < 10; i++) begin
            Instr_valid = (i < 4);
            tick();
        end
        Instr_valid = 1'b0;
        do_load(32'h8000_0010);
        tests_run++; if (Dout !== 32'd10) begin tests_failed++; $display("FAIL cnt_cycle got %0d want 10", Dout); end
        do_load(32'h8000_0014);
        tests_run++; if (Dout !== 32'd4) begin tests_failed++; $display("FAIL cnt_instr got %0d want 4", Dout); end
        Instr_valid = 1'b1;
        do_store(32'h8000_0018, 32'h0, 4'h2);
        Instr_valid = 1'b0;
        do_load(32'h8000_0010);
        tests_run++; if (Dout !== 32'd0) begin tests_failed++; $display("FAIL cnt_clr_cycle got %0d want 0", Dout); end
        do_load(32'h8000_0014);
        tests_run++; if (Dout !== 32'd0) begin tests_failed++; $display("FAIL cnt_clr_instr got %0d want 0", Dout); end
        do_load(32'h8000_0010);
        tests_run++; if (Dout !== 32'd2) begin tests_failed++; $display("FAIL cnt_resume got %0d want 2", Dout); end
    endtask

    task automatic test_unmapped();
        do_load(32'h1000_0010);
        tests_run++; if (Dout !== 32'h0) begin tests_failed++; $display("FAIL unmapped_load got %h want 0", Dout); end
        do_store(32'h0000_0008, 32'h5A, 4'h1);
        tests_run++; if (Tx_valid !== 1'b0) begin tests_failed++; $display("FAIL unmapped_store got %b want 0", Tx_valid); end
        do_push(8'h99);
        do_load(32'h8000_0010);
        A = 32'h8000_0004; Io_trans = 4'hF; Io_recv = 1'b1;
        tick();
        Io_trans = 4'h0; Io_recv = 1'b0;
        tests_run++; if (Dout !== 32'h0) begin tests_failed++; $display("FAIL store_load_dout got %h want 0", Dout); end
        do_load(32'h8000_0004);
        tests_run++; if (Dout !== 32'h99) begin tests_failed++; $display("FAIL store_load_nopop got %h want %h", Dout, 32'h99); end
    endtask

    task automatic test_reset_mid_hold();
        Tx_ready = 1'b0;
        do_store(32'h8000_0008, 32'h33, 4'h1);
        do_push(8'hC1);
        do_push(8'hC2);
        tests_run++; if (Tx_valid !== 1'b1) begin tests_failed++; $display("FAIL pre_reset_hold got %b want 1", Tx_valid); end
        apply_reset();
        tests_run++; if (Tx_valid !== 1'b0 || Rx_ready !== 1'b1 || Tx_data !== 8'h0) begin tests_failed++; $display("FAIL mid_reset got valid=%b rdy=%b data=%h want 0/1/00", Tx_valid, Rx_ready, Tx_data); end
        release_reset();
        do_load(32'h8000_0000);
        tests_run++; if (Dout !== 32'h1) begin tests_failed++; $display("FAIL post_reset_status got %h want %h", Dout, 32'h1); end
        do_load(32'h8000_0010);
        tests_run++; if (Dout !== 32'd1) begin tests_failed++; $display("FAIL post_reset_cycle got %0d want 1", Dout); end
        do_load(32'h8000_0004);
        tests_run++; if (Dout !== 32'h0) begin tests_failed++; $display("FAIL post_reset_fifo got %h want 0", Dout); end
    endtask

    initial begin
        test_reset();
        test_tx();
        test_rx_fill();
        test_simul_push_pop();
        test_no_bypass();
        test_counters();
        test_unmapped();
        test_reset_mid_hold();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/io_responder.md
IO_RESPONDER -- requirements
Module: io_responder

Interface
REQ-001 SHALL have parameter RX_DEPTH, default 4, RX FIFO depth in bytes (power of two, >= 2).
REQ-002 SHALL have parameter IO_BASE, default 4'h8, value of A[31:28] selecting the IO space.
REQ-003 SHALL have port Clock  input  1  single clock; all state rising-edge triggered.
REQ-004 SHALL have port Reset_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port A  input  32  load/store address from the execute stage.
REQ-006 SHALL have port Din  input  32  store data.
REQ-007 SHALL have port Io_trans  input  4  IO byte write enables from memory control; nonzero means IO store this cycle.
REQ-008 SHALL have port Io_recv  input  1  IO load this cycle.
REQ-009 SHALL have port Instr_valid  input  1  one instruction retired this cycle.
REQ-010 SHALL have port Dout  output  32  registered IO load data.
REQ-011 SHALL have port Tx_data  output  8  byte to UART transmitter.
REQ-012 SHALL have port Tx_valid  output  1  Tx_data valid.
REQ-013 SHALL have port Tx_ready  input  1  transmitter accepts byte.
REQ-014 SHALL have port Rx_data  input  8  byte from UART receiver.
REQ-015 SHALL have port Rx_valid  input  1  Rx_data valid.
REQ-016 SHALL have port Rx_ready  output  1  RX FIFO can accept a byte.

Function
REQ-017 SHALL treat an access as mapped only when A[31:28]==IO_BASE; decode on A[7:0]; unmapped stores are ignored, unmapped loads return 0.
REQ-018 SHALL return on load of 0x00 status {29'b0, tx_drop, rx_nonempty, tx_ready}, tx_ready = (tx state IDLE).
REQ-019 SHALL return on load of 0x04 {24'b0, FIFO head} and pop the FIFO when non-empty; empty FIFO returns 0, no pop.
REQ-020 SHALL on store to 0x08 with Io_trans[0]=1 in tx state IDLE latch Din[7:0] into Tx_data and enter HOLD; in HOLD drop the byte and set sticky tx_drop.
REQ-021 SHALL drive Tx_valid=1 exactly while in HOLD; HOLD -> IDLE on the edge where Tx_valid & Tx_ready; Tx_data stable throughout HOLD.
REQ-022 SHALL clear tx_drop on a status load; a drop in the same cycle wins (bit stays 1); the status load returns the pre-edge value.
REQ-023 SHALL drive Rx_ready = (FIFO count < RX_DEPTH), combinationally from registered count.
REQ-024 SHALL push Rx_data on Rx_valid & Rx_ready; pointers wrap modulo RX_DEPTH; simultaneous push and pop leaves count unchanged.
REQ-025 SHALL not bypass: pop on empty with same-cycle push returns 0 and the pushed byte remains queued (count 1).
REQ-026 SHALL keep a 32-bit cycle counter incrementing every cycle, read at 0x10, wrapping 0xFFFFFFFF -> 0.
REQ-027 SHALL keep a 32-bit instruction counter incrementing when Instr_valid, read at 0x14, wrapping likewise.
REQ-028 SHALL on any store (Io_trans nonzero) to 0x18 set both counters to 0 at that edge, overriding that cycle's increment.
REQ-029 SHALL register Dout at the edge where Io_recv=1 (1-cycle load latency); Dout holds when Io_recv=0; counter loads return pre-edge value.
REQ-030 SHALL, if Io_trans nonzero and Io_recv=1 together, perform the store, no pop, and load Dout with 0.

Reset
REQ-031 SHALL on Reset_n low immediately: Dout=0, Tx_data=0, Tx_valid=0, tx state IDLE, tx_drop=0, FIFO empty (Rx_ready=1), both counters 0.
REQ-032 SHALL on reset mid-operation abandon any HOLD byte and discard FIFO contents; no handshake completes during reset.
REQ-033 SHALL resume counting on the first rising edge after Reset_n deasserts (cycle counter 1 after that edge).

Verification
REQ-034 SHALL verify TX: store 0x80000008 Din=0x41, Tx_ready=0 3 cycles -> Tx_valid=1, Tx_data=0x41 held; second store 0x42 dropped, status load = 0x4; Tx_ready=1 -> Tx_valid=0 next cycle, status = 0x1.
REQ-035 SHALL verify RX fill: push 0x11,0x22,0x33,0x44 -> Rx_ready=0; extra Rx_valid ignored; four 0x04 loads return 0x11,0x22,0x33,0x44, then 0.
REQ-036 SHALL verify simultaneous push/pop with count 2: count stays 2, FIFO order preserved across pointer wrap.
REQ-037 SHALL verify counters: 10 cycles after reset, Instr_valid 4 of them -> 0x10 load ~=10, 0x14 load=4; store 0x18 -> next load of 0x10 returns small value, 0x14 returns 0.
REQ-038 SHALL verify unmapped/illegal: load A=0x10000010 -> Dout=0; Io_trans=4'hF with Io_recv=1 -> Dout=0, no FIFO pop.
REQ-039 SHALL verify reset mid-HOLD with 2 bytes queued -> Tx_valid=0, Rx_ready=1, status=0x1 immediately after release.
